// File: rtl/mcs8_bus_ctrl.sv
// mcs8_bus_ctrl: responder on the far end of the MCS8 multiplexed bus.
// Demultiplexes the T1/T2 address bytes and cycle type, runs one memory or
// I/O transaction per CPU cycle on a request/ack port, returns read data in
// T3 and stretches the CPU through READY_O until the slave answers.
module mcs8_bus_ctrl #(
    parameter logic [7:0] INT_VEC_RST = 8'h05
) (
    input  logic        CLK_I,
    input  logic        nRST_I,
    input  logic        SYNC_I,
    input  logic [2:0]  STATE_I,
    input  logic [7:0]  DATA_I,
    output logic [7:0]  DATA_O,
    output logic        DATA_OE_O,
    output logic        READY_O,
    output logic [13:0] MEM_ADDR_O,
    output logic        MEM_RD_O,
    output logic        MEM_WR_O,
    output logic [7:0]  MEM_WDATA_O,
    input  logic [7:0]  MEM_RDATA_I,
    input  logic        MEM_ACK_I,
    output logic [4:0]  IO_PORT_O,
    output logic        IO_RD_O,
    output logic        IO_WR_O,
    output logic [7:0]  IO_WDATA_O,
    input  logic [7:0]  IO_RDATA_I,
    input  logic        IO_ACK_I
);

    localparam logic [2:0] ST_T1  = 3'b010;
    localparam logic [2:0] ST_T2  = 3'b100;
    localparam logic [2:0] ST_T3  = 3'b001;
    localparam logic [2:0] ST_T1I = 3'b110;

    localparam logic [1:0] CYC_PCI = 2'b00;
    localparam logic [1:0] CYC_PCC = 2'b01;
    localparam logic [1:0] CYC_PCR = 2'b10;

    // WARM: write armed, waiting for T3 data. WISS: write issued, waiting for ACK.
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_REQ, S_HOLD, S_WARM, S_WISS
    } state_t;

    state_t      r_state;
    logic [7:0]  r_addr_l;
    logic [5:0]  r_addr_h;
    logic [1:0]  r_cyc;
    logic        r_int;
    logic        r_io;      // outstanding/armed transaction targets the I/O port
    logic        r_nt1;     // next cycle's T1 seen while a write is outstanding
    logic        r_q;       // next cycle's T2 seen while a write is outstanding
    logic [13:0] r_mem_addr;
    logic [4:0]  r_port;
    logic [7:0]  r_wdata;
    logic [7:0]  r_rdata;
    logic        r_mem_rd, r_mem_wr, r_io_rd, r_io_wr;

    logic        w_t1, w_t2, w_t3;
    logic        w_ack;
    logic [7:0]  w_ack_data;
    logic        w_launch_now, w_launch_q, w_launch;
    logic [7:0]  w_l_byte;
    logic [1:0]  w_l_cyc;
    logic [5:0]  w_l_ah;
    logic        w_l_pcc, w_l_read, w_l_vec;

    assign w_t1 = SYNC_I && (STATE_I == ST_T1 || STATE_I == ST_T1I);
    assign w_t2 = SYNC_I && (STATE_I == ST_T2);
    assign w_t3 = SYNC_I && (STATE_I == ST_T3);

    // Only the port that owns the outstanding request can complete it.
    assign w_ack      = r_io ? IO_ACK_I : MEM_ACK_I;
    assign w_ack_data = r_io ? IO_RDATA_I : MEM_RDATA_I;

    // A cycle is launched straight from the T2 byte, or from the queued T2
    // byte once the write ahead of it has been acknowledged.
    assign w_launch_now = w_t2 && ((r_state == S_ADDR) ||
                          (r_state == S_WISS && r_nt1 && !r_q && w_ack));
    assign w_launch_q   = (r_state == S_WISS) && r_q && w_ack;
    assign w_launch     = w_launch_now || w_launch_q;

    assign w_l_byte = w_launch_q ? {r_cyc, r_addr_h} : DATA_I;
    assign w_l_cyc  = w_l_byte[7:6];
    assign w_l_ah   = w_l_byte[5:0];
    assign w_l_pcc  = (w_l_cyc == CYC_PCC);
    assign w_l_read = (w_l_cyc == CYC_PCI) || (w_l_cyc == CYC_PCR) ||
                      (w_l_pcc && (w_l_ah[5:4] == 2'b00));
    assign w_l_vec  = (w_l_cyc == CYC_PCI) && r_int;

    // Bus sequencing FSM with all request strobes and data latches.
    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            r_state    <= S_IDLE;
            r_addr_l   <= '0;
            r_addr_h   <= '0;
            r_cyc      <= '0;
            r_int      <= 1'b0;
            r_io       <= 1'b0;
            r_nt1      <= 1'b0;
            r_q        <= 1'b0;
            r_mem_addr <= '0;
            r_port     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_io_rd    <= 1'b0;
            r_io_wr    <= 1'b0;
        end else begin
            if (w_t1) begin
                r_addr_l <= DATA_I;
                r_int    <= (STATE_I == ST_T1I);
            end
            if (w_t2) begin
                r_addr_h <= DATA_I[5:0];
                r_cyc    <= DATA_I[7:6];
            end

            case (r_state)
                S_IDLE: if (w_t1) r_state <= S_ADDR;
                S_ADDR: ;
                S_REQ: begin
                    if (w_ack) begin
                        r_mem_rd <= 1'b0;
                        r_io_rd  <= 1'b0;
                        r_rdata  <= w_ack_data;
                        r_state  <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_t3) begin
                        r_int   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_WARM: begin
                    if (w_t3) begin
                        if (r_io) r_io_wr  <= 1'b1;
                        else      r_mem_wr <= 1'b1;
                        // OUT carries the T1 byte; memory writes carry the T3 byte.
                        r_wdata <= r_io ? r_addr_l : DATA_I;
                        r_nt1   <= 1'b0;
                        r_q     <= 1'b0;
                        r_state <= S_WISS;
                    end
                end
                S_WISS: begin
                    if (w_t1)          r_nt1 <= 1'b1;
                    if (w_t2 && r_nt1) r_q   <= 1'b1;
                    if (w_ack) begin
                        r_mem_wr <= 1'b0;
                        r_io_wr  <= 1'b0;
                        r_state  <= (r_nt1 || w_t1) ? S_ADDR : S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Launch overrides the per-state next state above.
            if (w_launch) begin
                r_mem_addr <= {w_l_ah, r_addr_l};
                r_port     <= w_l_ah[5:1];
                r_io       <= w_l_pcc;
                r_nt1      <= 1'b0;
                r_q        <= 1'b0;
                if (w_l_vec) begin
                    r_rdata <= INT_VEC_RST;
                    r_state <= S_HOLD;
                end else if (w_l_read) begin
                    if (w_l_pcc) r_io_rd  <= 1'b1;
                    else         r_mem_rd <= 1'b1;
                    r_state <= S_REQ;
                end else begin
                    r_state <= S_WARM;
                end
            end
        end
    end

    // READY follows ACK combinationally so a same-clock ACK never stalls the CPU.
    assign READY_O = !(((r_state == S_REQ) && !w_ack) || ((r_state == S_WISS) && r_q));

    assign DATA_OE_O   = (r_state == S_HOLD) && (STATE_I == ST_T3);
    assign DATA_O      = r_rdata;
    assign MEM_ADDR_O  = r_mem_addr;
    assign MEM_RD_O    = r_mem_rd;
    assign MEM_WR_O    = r_mem_wr;
    assign MEM_WDATA_O = r_wdata;
    assign IO_PORT_O   = r_port;
    assign IO_RD_O     = r_io_rd;
    assign IO_WR_O     = r_io_wr;
    assign IO_WDATA_O  = r_wdata;

endmodule

// File: tb/tb_mcs8_bus_ctrl.sv
// Directed bench for mcs8_bus_ctrl: drives CPU bus T-states and slave ACKs,
// checks outputs against hand-computed values.
module tb_mcs8_bus_ctrl;

    localparam logic [2:0] T1 = 3'b010, T2 = 3'b100, T3 = 3'b001, T4 = 3'b111;
    localparam logic [2:0] T5 = 3'b101, T1I = 3'b110, TW = 3'b000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync = 1'b0;
    logic [2:0]  st = TW;
    logic [7:0]  din = '0;
    logic [7:0]  dout;
    logic        oe, rdy;
    logic [13:0] maddr;
    logic        mrd, mwr;
    logic [7:0]  mwdata;
    logic [7:0]  mrdata = '0;
    logic        mack = 1'b0;
    logic [4:0]  port;
    logic        iord, iowr;
    logic [7:0]  iowdata;
    logic [7:0]  iordata = '0;
    logic        iack = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mcs8_bus_ctrl dut (
        .CLK_I(clk), .nRST_I(rst_n), .SYNC_I(sync), .STATE_I(st), .DATA_I(din),
        .DATA_O(dout), .DATA_OE_O(oe), .READY_O(rdy),
        .MEM_ADDR_O(maddr), .MEM_RD_O(mrd), .MEM_WR_O(mwr), .MEM_WDATA_O(mwdata),
        .MEM_RDATA_I(mrdata), .MEM_ACK_I(mack),
        .IO_PORT_O(port), .IO_RD_O(iord), .IO_WR_O(iowr), .IO_WDATA_O(iowdata),
        .IO_RDATA_I(iordata), .IO_ACK_I(iack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present one bus sample (strobe) and let combinational outputs settle.
    task automatic drv(input logic [2:0] s, input logic [7:0] d);
        sync = 1'b1; st = s; din = d; #1;
    endtask

    // Advance one clock; sample point is just after the edge.
    task automatic clk1();
        @(posedge clk); #1; sync = 1'b0;
    endtask

    initial begin
        // reset state
        #3;
        chk("rst_ready", rdy, 1); chk("rst_mrd", mrd, 0); chk("rst_mwr", mwr, 0);
        chk("rst_iord", iord, 0); chk("rst_iowr", iowr, 0); chk("rst_oe", oe, 0);
        chk("rst_dout", dout, 0); chk("rst_maddr", maddr, 0);
        @(posedge clk); #1; rst_n = 1'b1;

        // T2 with no preceding T1 is ignored
        drv(T2, 8'h12); clk1();
        chk("orphan_t2_mrd", mrd, 0); chk("orphan_t2_rdy", rdy, 1);

        // PCI zero-wait read from 0x1234
        drv(T1, 8'h34); clk1();
        drv(T2, 8'h12); clk1();
        chk("pci_mrd", mrd, 1); chk("pci_addr", maddr, 14'h1234);
        mack = 1'b1; mrdata = 8'hC3; #1;
        chk("pci_rdy_zw", rdy, 1);
        clk1(); mack = 1'b0; mrdata = 8'h00; #1;
        chk("pci_mrd_drop", mrd, 0); chk("pci_rdy_after", rdy, 1);
        drv(T3, 8'h00);
        chk("pci_oe", oe, 1); chk("pci_data", dout, 8'hC3);
        clk1();
        chk("pci_oe_off", oe, 0);

        // PCR read, ACK delayed 5 clocks, WAIT strobes ignored
        drv(T1, 8'h78); clk1();
        drv(T2, 8'h85); clk1();
        chk("pcr_addr", maddr, 14'h0578);
        for (int i = 0; i < 5; i++) begin
            drv(TW, 8'h00);
            chk("pcr_rdy_low", rdy, 0); chk("pcr_mrd_hold", mrd, 1);
            clk1();
        end
        mack = 1'b1; mrdata = 8'h5A; drv(TW, 8'h00);
        chk("pcr_rdy_ack", rdy, 1);
        clk1(); mack = 1'b0; #1;
        drv(T3, 8'h00);
        chk("pcr_oe", oe, 1); chk("pcr_data", dout, 8'h5A);
        clk1();

        // PCW to 0x3FFF, then a read queued behind the unacked write
        drv(T1, 8'hFF); clk1();
        drv(T2, 8'hFF); clk1();
        chk("pcw_no_wr_yet", mwr, 0); chk("pcw_rdy", rdy, 1);
        drv(T3, 8'hA7); clk1();
        chk("pcw_mwr", mwr, 1); chk("pcw_addr", maddr, 14'h3FFF); chk("pcw_wdata", mwdata, 8'hA7);
        drv(T4, 8'h00); clk1();
        drv(T5, 8'h00); clk1();
        drv(T1, 8'h10); clk1();
        chk("q_rdy_before_t2", rdy, 1);
        drv(T2, 8'h20); clk1();
        chk("q_rdy_low", rdy, 0); chk("q_mwr_hold", mwr, 1);
        chk("q_mrd_wait", mrd, 0); chk("q_addr_hold", maddr, 14'h3FFF);
        drv(TW, 8'h00); clk1();
        mack = 1'b1; drv(TW, 8'h00);
        chk("q_rdy_wr_ack", rdy, 0);
        clk1(); mack = 1'b0; #1;
        chk("q_mwr_drop", mwr, 0); chk("q_mrd_issue", mrd, 1);
        chk("q_rd_addr", maddr, 14'h2010); chk("q_rdy_rd", rdy, 0);
        drv(TW, 8'h00); clk1();
        mack = 1'b1; mrdata = 8'h66; drv(TW, 8'h00);
        chk("q_rdy_rd_ack", rdy, 1);
        clk1(); mack = 1'b0; #1;
        drv(T3, 8'h00);
        chk("q_data", dout, 8'h66); chk("q_oe", oe, 1);
        clk1();

        // PCC OUT to port 9 carries the T1 byte
        drv(T1, 8'h99); clk1();
        drv(T2, 8'h52); clk1();
        chk("out_no_wr_yet", iowr, 0);
        drv(T3, 8'h11); clk1();
        chk("out_iowr", iowr, 1); chk("out_port", port, 5'd9);
        chk("out_wdata", iowdata, 8'h99); chk("out_mwr", mwr, 0);
        iack = 1'b1; #1;
        chk("out_rdy", rdy, 1);
        clk1(); iack = 1'b0; #1;
        chk("out_iowr_drop", iowr, 0);

        // PCC INP from port 3
        drv(T1, 8'h00); clk1();
        drv(T2, 8'h46); clk1();
        chk("inp_iord", iord, 1); chk("inp_port", port, 5'd3); chk("inp_mrd", mrd, 0);
        iack = 1'b1; iordata = 8'h3C; #1;
        chk("inp_rdy", rdy, 1);
        clk1(); iack = 1'b0; #1;
        chk("inp_iord_drop", iord, 0);
        drv(T3, 8'h00);
        chk("inp_data", dout, 8'h3C); chk("inp_oe", oe, 1);
        clk1();

        // Interrupt acknowledge: T1I then PCI returns the vector
        drv(T1I, 8'h00); clk1();
        drv(T2, 8'h00); clk1();
        chk("int_no_mrd", mrd, 0); chk("int_rdy", rdy, 1);
        drv(T3, 8'h00);
        chk("int_data", dout, 8'h05); chk("int_oe", oe, 1);
        clk1();
        drv(T1, 8'h01); clk1();
        drv(T2, 8'h02); clk1();
        chk("after_int_mrd", mrd, 1); chk("after_int_addr", maddr, 14'h0201);
        mack = 1'b1; mrdata = 8'h9E; #1;
        clk1(); mack = 1'b0; #1;
        drv(T3, 8'h00);
        chk("after_int_data", dout, 8'h9E);
        clk1();

        // Reset mid-transaction, orphaned ACK, then normal operation
        drv(T1, 8'h55); clk1();
        drv(T2, 8'h0A); clk1();
        chk("mid_mrd", mrd, 1);
        rst_n = 1'b0; #1;
        chk("mid_rst_mrd", mrd, 0); chk("mid_rst_addr", maddr, 0); chk("mid_rst_rdy", rdy, 1);
        @(posedge clk); #1; rst_n = 1'b1;
        mack = 1'b1; mrdata = 8'hEE; clk1(); mack = 1'b0; #1;
        chk("orphan_ack_mrd", mrd, 0); chk("orphan_ack_dout", dout, 0);
        drv(T1, 8'hAB); clk1();
        drv(T2, 8'h01); clk1();
        chk("post_rst_mrd", mrd, 1); chk("post_rst_addr", maddr, 14'h01AB);
        mack = 1'b1; mrdata = 8'h77; #1;
        clk1(); mack = 1'b0; #1;
        drv(T3, 8'h00);
        chk("post_rst_data", dout, 8'h77); chk("post_rst_oe", oe, 1);
        clk1();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
